// File: rtl/shot_tracer.sv
// Projectile tracer: launches from the launcher column, steps one row every STEP_DIV cycles, reflects off the side walls.
// Latency: the launch is visible on the edge that samples fire; flight lasts (GRID_H-1)*STEP_DIV cycles, then a 1-cycle done pulse.
// Backpressure: none; fire is only accepted in IDLE and is otherwise ignored, with no queuing.
module shot_tracer #(
    parameter int STEP_DIV = 4,
    parameter int GRID_H   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [4:0] x_pos,
    input  logic [2:0] aim_pos,
    output logic [4:0] shot_x,
    output logic [3:0] shot_y,
    output logic       shot_active,
    output logic       shot_done,
    output logic [2:0] bounce_cnt
);

    localparam int             CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [3:0]     Y_LAST   = 4'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [2:0]  dx_q, dx_d;
    logic [4:0]         x_d;
    logic [3:0]         y_d;
    logic [2:0]         b_d;
    logic signed [6:0]  nx;
    logic [2:0]         aim_c;
    logic [3:0]         y_inc;

    // Next-state and next-datapath values; every step and the launch are decided here.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        x_d     = shot_x;
        y_d     = shot_y;
        b_d     = bounce_cnt;
        // 7-bit signed so that both under- and overflow of the 0..31 field are representable.
        nx      = $signed({2'b00, shot_x}) + $signed({{4{dx_q[2]}}, dx_q});
        // Aim 7 would give dx=+4; it is folded onto 6 so the slope stays symmetric.
        aim_c   = (aim_pos == 3'd7) ? 3'd6 : aim_pos;
        y_inc   = shot_y + 4'd1;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    x_d     = x_pos;
                    y_d     = 4'd0;
                    b_d     = 3'd0;
                    cnt_d   = '0;
                    dx_d    = aim_c - 3'd3;
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    y_d   = y_inc;
                    if (nx > 7'sd31) begin
                        x_d  = 5'(7'sd62 - nx);
                        dx_d = -dx_q;
                        b_d  = (bounce_cnt == 3'd7) ? 3'd7 : bounce_cnt + 3'd1;
                    end else if (nx < 7'sd0) begin
                        x_d  = 5'(-nx);
                        dx_d = -dx_q;
                        b_d  = (bounce_cnt == 3'd7) ? 3'd7 : bounce_cnt + 3'd1;
                    end else begin
                        x_d = nx[4:0];
                    end
                    if (y_inc == Y_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; reset aborts any flight in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered datapath and status flags, derived from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            dx_q        <= 3'sd0;
            shot_x      <= 5'd0;
            shot_y      <= 4'd0;
            bounce_cnt  <= 3'd0;
            shot_active <= 1'b0;
            shot_done   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dx_q        <= dx_d;
            shot_x      <= x_d;
            shot_y      <= y_d;
            bounce_cnt  <= b_d;
            shot_active <= (state_d == FLIGHT);
            shot_done   <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_shot_tracer.sv
// Testbench for shot_tracer: scoreboard of expected per-step trajectory events.
// Latency: checks each step lands STEP_DIV cycles apart and done lands at (GRID_H-1)*STEP_DIV.
// Backpressure: none; stimulus and monitor are decoupled through the expectation queue.
module tb_shot_tracer;

    localparam int SD = 4;
    localparam int GH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       fire;
    logic [4:0] x_pos;
    logic [2:0] aim_pos;
    logic [4:0] shot_x;
    logic [3:0] shot_y;
    logic       shot_active;
    logic       shot_done;
    logic [2:0] bounce_cnt;

    always #5 clk = ~clk;

    shot_tracer #(.STEP_DIV(SD), .GRID_H(GH)) dut (
        .clk         (clk),
        .reset       (reset),
        .fire        (fire),
        .x_pos       (x_pos),
        .aim_pos     (aim_pos),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_active (shot_active),
        .shot_done   (shot_done),
        .bounce_cnt  (bounce_cnt)
    );

    typedef struct {
        int act;
        int done;
        int x;
        int y;
        int b;
        int cyc;
        int gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   obs_x[GH];
    int   obs_b[GH];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference trajectory: launch event, then one event per row; the last row is the done event.
    task automatic plan_shot(input int x0, input int aim, input int gap);
        exp_t e;
        int x, dx, b, nx;
        dx = (aim == 7) ? 3 : aim - 3;
        x  = x0;
        b  = 0;
        e  = '{1, 0, x0, 0, 0, 0, gap};
        q.push_back(e);
        for (int y = 1; y < GH; y++) begin
            nx = x + dx;
            if (nx > 31) begin
                x  = 62 - nx;
                dx = -dx;
                b  = (b < 7) ? b + 1 : 7;
            end else if (nx < 0) begin
                x  = -nx;
                dx = -dx;
                b  = (b < 7) ? b + 1 : 7;
            end else begin
                x = nx;
            end
            e = '{(y != GH-1) ? 1 : 0, (y == GH-1) ? 1 : 0, x, y, b, y*SD, -1};
            q.push_back(e);
        end
    endtask

    task automatic shoot(input int x, input int aim);
        @(negedge clk);
        x_pos   = 5'(x);
        aim_pos = 3'(aim);
        fire    = 1'b1;
        @(negedge clk);
        fire    = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, q.size(), 0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: an event is a launch, a row change in flight, or the done pulse.
    initial begin
        int    prev_act;
        int    prev_y;
        int    since_l;
        int    since_d;
        bit    ev;
        exp_t  e;
        string tag;
        prev_act = 0;
        prev_y   = 0;
        since_l  = 0;
        since_d  = 1000;
        forever begin
            @(negedge clk);
            since_l++;
            since_d++;
            if (!reset) begin
                prev_act = 0;
                prev_y   = 0;
                continue;
            end
            ev = (shot_active && prev_act == 0) ||
                 (shot_active && int'(shot_y) != prev_y) || shot_done;
            if (ev) begin
                if (shot_active && prev_act == 0) since_l = 0;
                if (q.size() == 0) begin
                    chk("unexpected_event_row", int'(shot_y), -1);
                end else begin
                    e   = q.pop_front();
                    tag = $sformatf("row%0d", e.y);
                    chk({tag, "_x"},      int'(shot_x),      e.x);
                    chk({tag, "_y"},      int'(shot_y),      e.y);
                    chk({tag, "_bounce"}, int'(bounce_cnt),  e.b);
                    chk({tag, "_active"}, int'(shot_active), e.act);
                    chk({tag, "_done"},   int'(shot_done),   e.done);
                    chk({tag, "_cycle"},  since_l,           e.cyc);
                    if (e.gap >= 0) chk({tag, "_relaunch_gap"}, since_d, e.gap);
                end
                obs_x[shot_y] = int'(shot_x);
                obs_b[shot_y] = int'(bounce_cnt);
                if (shot_done) since_d = 0;
            end
            prev_act = int'(shot_active);
            prev_y   = int'(shot_y);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        reset   = 1'b0;
        fire    = 1'b0;
        x_pos   = 5'd0;
        aim_pos = 3'd0;
        #1;
        chk("reset_x",      int'(shot_x),      0);
        chk("reset_y",      int'(shot_y),      0);
        chk("reset_active", int'(shot_active), 0);
        chk("reset_done",   int'(shot_done),   0);
        chk("reset_bounce", int'(bounce_cnt),  0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Straight shot.
        plan_shot(10, 3, -1);
        shoot(10, 3);
        drain("straight", 200);
        chk("straight_x_row1",   obs_x[1],  10);
        chk("straight_x_row15",  obs_x[15], 10);
        chk("straight_b_row15",  obs_b[15], 0);

        // Right wall.
        plan_shot(30, 6, -1);
        shoot(30, 6);
        drain("right", 200);
        chk("right_x_row1",  obs_x[1],  29);
        chk("right_b_row1",  obs_b[1],  1);
        chk("right_x_row2",  obs_x[2],  26);
        chk("right_x_row15", obs_x[15], 13);
        chk("right_b_row15", obs_b[15], 2);

        // Clamped aim 7, touching column 31 without bouncing.
        plan_shot(1, 7, -1);
        shoot(1, 7);
        drain("clamp", 200);
        chk("clamp_x_row1",  obs_x[1],  4);
        chk("clamp_x_row10", obs_x[10], 31);
        chk("clamp_b_row10", obs_b[10], 0);
        chk("clamp_x_row11", obs_x[11], 28);
        chk("clamp_b_row15", obs_b[15], 1);

        // Left wall.
        plan_shot(1, 0, -1);
        shoot(1, 0);
        drain("left", 200);
        chk("left_x_row1",  obs_x[1],  2);
        chk("left_b_row1",  obs_b[1],  1);
        chk("left_x_row2",  obs_x[2],  5);
        chk("left_x_row15", obs_x[15], 18);
        chk("left_b_row15", obs_b[15], 2);

        // Fire held, inputs changed mid-flight, relaunch on the first IDLE edge.
        plan_shot(5, 4, -1);
        plan_shot(20, 1, 2);
        @(negedge clk);
        x_pos   = 5'd5;
        aim_pos = 3'd4;
        fire    = 1'b1;
        repeat (10) @(negedge clk);
        x_pos   = 5'd20;
        aim_pos = 3'd1;
        repeat (60) @(negedge clk);
        fire    = 1'b0;
        drain("held", 300);
        chk("held_x_row10", obs_x[10], 0);
        chk("held_b_row10", obs_b[10], 0);
        chk("held_x_row11", obs_x[11], 2);
        chk("held_x_row15", obs_x[15], 10);
        chk("held_b_row15", obs_b[15], 1);

        // Reset in mid-flight.
        plan_shot(12, 5, -1);
        shoot(12, 5);
        for (int i = 0; i < 200 && shot_y != 4'd7; i++) @(negedge clk);
        chk("rst_reach_row7", int'(shot_y), 7);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_x",      int'(shot_x),      0);
        chk("rst_async_y",      int'(shot_y),      0);
        chk("rst_async_active", int'(shot_active), 0);
        chk("rst_async_done",   int'(shot_done),   0);
        chk("rst_async_bounce", int'(bounce_cnt),  0);
        chk("rst_rows_left",    q.size(),          8);
        q.delete();
        repeat (5) @(negedge clk);
        plan_shot(3, 3, -1);
        x_pos   = 5'd3;
        aim_pos = 3'd3;
        fire    = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        fire    = 1'b0;
        drain("after_rst", 200);
        chk("after_rst_x_row15", obs_x[15], 3);
        chk("after_rst_b_row15", obs_b[15], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
